// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared sizing helpers for the Vedic multiplier pipeline
//
// Purpose: width helpers and the operand-width legality check used by
// vedic_nxn_pipe and vedic_mul_comb. No ports (package).
package vedic_pkg;

  localparam int VEDIC_MIN_W = 4;

  // Half of an operand width: the split point between high and low halves.
  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  // Width of an unsigned w x w product.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Recursive halving must land exactly on the 2x2 leaf.
  function automatic bit width_ok(input int w);
    return (w >= VEDIC_MIN_W) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/vedic_mul_comb.sv
// rtl/vedic_mul_comb.sv - combinational recursive Urdhva-Tiryagbhyam multiplier
//
// Purpose: unsigned W x W product, built by splitting each operand in half,
// forming four half-width products and recombining them; recursion stops
// at a gate-level 2x2 leaf. W must be a power of two >= 2.
// Ports:
//   a_i [W-1:0]    operand A
//   b_i [W-1:0]    operand B
//   p_o [2*W-1:0]  product A*B
module vedic_mul_comb #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  if (W == 2) begin : g_leaf
    logic t1, t2, c1, hh;
    assign t1 = a_i[1] & b_i[0];
    assign t2 = a_i[0] & b_i[1];
    assign c1 = t1 & t2;
    assign hh = a_i[1] & b_i[1];
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = t1 ^ t2;
    assign p_o[2] = hh ^ c1;
    assign p_o[3] = hh & c1;
  end else begin : g_split
    localparam int HW = W / 2;
    logic [W-1:0] ll, hl, lh, hh;
    logic [W:0]   mid;

    vedic_mul_comb #(.W(HW)) u_ll (.a_i(a_i[HW-1:0]), .b_i(b_i[HW-1:0]), .p_o(ll));
    vedic_mul_comb #(.W(HW)) u_hl (.a_i(a_i[W-1:HW]), .b_i(b_i[HW-1:0]), .p_o(hl));
    vedic_mul_comb #(.W(HW)) u_lh (.a_i(a_i[HW-1:0]), .b_i(b_i[W-1:HW]), .p_o(lh));
    vedic_mul_comb #(.W(HW)) u_hh (.a_i(a_i[W-1:HW]), .b_i(b_i[W-1:HW]), .p_o(hh));

    // Cross terms keep their carry; hh and ll never overlap so they concatenate.
    assign mid = {1'b0, hl} + {1'b0, lh};
    assign p_o = {hh, ll} + ({{(W - 1){1'b0}}, mid} << HW);
  end

endmodule

// File: rtl/vedic_nxn_pipe.sv
// rtl/vedic_nxn_pipe.sv - two-stage pipelined Vedic multiplier with A/B stream join
//
// Purpose: joins operand streams A and B, registers four half-width partial
// products (stage 1), recombines them into the full product (stage 2) and
// presents it on a handshaked result stream with full backpressure.
// Optional feature macro VEDIC_TAG_EN: adds s_a_tuser/m_tuser, a tag that
// travels with operand A through both stages.
// Ports:
//   clk, arst                     clock, asynchronous active-high reset
//   s_a_tdata/tvalid/tready       operand A stream
//   s_b_tdata/tvalid/tready       operand B stream
//   m_result_tdata/m_tvalid/m_tready  product stream (2*WIDTH bits)
//   s_a_tuser, m_tuser            tag in/out (VEDIC_TAG_EN only)
module vedic_nxn_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [WIDTH-1:0]     s_a_tdata,
  input  logic                 s_a_tvalid,
  output logic                 s_a_tready,
  input  logic [WIDTH-1:0]     s_b_tdata,
  input  logic                 s_b_tvalid,
  output logic                 s_b_tready,
`ifdef VEDIC_TAG_EN
  input  logic [TAG_W-1:0]     s_a_tuser,
  output logic [TAG_W-1:0]     m_tuser,
`endif
  output logic [2*WIDTH-1:0]   m_result_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready
);

  localparam int H   = half_w(WIDTH);
  localparam int PW  = prod_w(WIDTH);
  localparam int PPW = prod_w(H);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_nxn_pipe: WIDTH must be a power of two >= 4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("vedic_nxn_pipe: TAG_W must be >= 1");
  end

  typedef struct packed {
    logic [PPW-1:0] ll;
    logic [PPW-1:0] hl;
    logic [PPW-1:0] lh;
    logic [PPW-1:0] hh;
  } pp_t;

  logic          adv1, adv2, accept;
  logic          v1_q, v1_d;
  logic          mv_q, mv_d;
  pp_t           pp_q, pp_d, pp_new;
  logic [PW-1:0] res_q, res_d, res_sum;
  logic [WIDTH:0] mid;
  logic [PPW-1:0] p_ll, p_hl, p_lh, p_hh;

  vedic_mul_comb #(.W(H)) u_mul_ll (.a_i(s_a_tdata[H-1:0]),     .b_i(s_b_tdata[H-1:0]),     .p_o(p_ll));
  vedic_mul_comb #(.W(H)) u_mul_hl (.a_i(s_a_tdata[WIDTH-1:H]), .b_i(s_b_tdata[H-1:0]),     .p_o(p_hl));
  vedic_mul_comb #(.W(H)) u_mul_lh (.a_i(s_a_tdata[H-1:0]),     .b_i(s_b_tdata[WIDTH-1:H]), .p_o(p_lh));
  vedic_mul_comb #(.W(H)) u_mul_hh (.a_i(s_a_tdata[WIDTH-1:H]), .b_i(s_b_tdata[WIDTH-1:H]), .p_o(p_hh));

  always_comb begin
    pp_new = '{ll: p_ll, hl: p_hl, lh: p_lh, hh: p_hh};
  end

  // Middle term is H*2+1 bits so its carry lands in the upper half.
  always_comb begin
    mid     = {1'b0, pp_q.hl} + {1'b0, pp_q.lh};
    res_sum = {pp_q.hh, pp_q.ll} + ({{(WIDTH - 1){1'b0}}, mid} << H);
  end

  // Join: both operands move together or not at all. Gating with arst keeps
  // the readys low for the whole time reset is held.
  always_comb begin
    adv2   = ~mv_q | m_tready;
    adv1   = ~v1_q | adv2;
    accept = s_a_tvalid & s_b_tvalid & adv1 & ~arst;
  end

  always_comb begin
    v1_d  = v1_q;
    pp_d  = pp_q;
    mv_d  = mv_q;
    res_d = res_q;
    if (adv1) begin
      v1_d = accept;
      if (accept) pp_d = pp_new;
    end
    if (adv2) begin
      mv_d = v1_q;
      if (v1_q) res_d = res_sum;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v1_q  <= 1'b0;
      pp_q  <= '0;
      mv_q  <= 1'b0;
      res_q <= '0;
    end else begin
      v1_q  <= v1_d;
      pp_q  <= pp_d;
      mv_q  <= mv_d;
      res_q <= res_d;
    end
  end

`ifdef VEDIC_TAG_EN
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;

  always_comb begin
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    if (adv1 && accept) tag1_d = s_a_tuser;
    if (adv2 && v1_q)   tag2_d = tag1_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  assign m_tuser = tag2_q;
`endif

  assign s_a_tready     = accept;
  assign s_b_tready     = accept;
  assign m_tvalid       = mv_q;
  assign m_result_tdata = res_q;

endmodule

// File: tb/tb_vedic_nxn_pipe.sv
// tb/tb_vedic_nxn_pipe.sv - directed and random self-checking bench for vedic_nxn_pipe
module tb_vedic_nxn_pipe;

  localparam int W     = 8;
  localparam int TAG_W = 4;
  localparam int N_RND = 1000;

  logic           clk;
  logic           arst;
  logic [W-1:0]   s_a_tdata, s_b_tdata;
  logic           s_a_tvalid, s_b_tvalid;
  logic           s_a_tready, s_b_tready;
  logic [2*W-1:0] m_result_tdata;
  logic           m_tvalid, m_tready;
`ifdef VEDIC_TAG_EN
  logic [TAG_W-1:0] s_a_tuser, m_tuser;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  vedic_nxn_pipe #(.WIDTH(W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .arst           (arst),
    .s_a_tdata      (s_a_tdata),
    .s_a_tvalid     (s_a_tvalid),
    .s_a_tready     (s_a_tready),
    .s_b_tdata      (s_b_tdata),
    .s_b_tvalid     (s_b_tvalid),
    .s_b_tready     (s_b_tready),
`ifdef VEDIC_TAG_EN
    .s_a_tuser      (s_a_tuser),
    .m_tuser        (m_tuser),
`endif
    .m_result_tdata (m_result_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic va, input logic vb);
    s_a_tdata  = a;
    s_b_tdata  = b;
    s_a_tvalid = va;
    s_b_tvalid = vb;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2*W-1:0] d);
    check({tag, "_v"}, 64'(m_tvalid), 64'(v));
    if (v) check({tag, "_d"}, 64'(m_result_tdata), 64'(d));
  endtask

  task automatic check_rdy(input string tag, input logic r);
    #1;
    check({tag, "_ra"}, 64'(s_a_tready), 64'(r));
    check({tag, "_rb"}, 64'(s_b_tready), 64'(r));
  endtask

  logic [2*W-1:0]   exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  logic             acc_last;
  int               acc, outs, cyc;
  logic [2*W-1:0]   e;
  logic [TAG_W-1:0] et;

  initial begin
    arst     = 1'b1;
    m_tready = 1'b0;
    drive(8'h12, 8'h34, 1'b1, 1'b1);
`ifdef VEDIC_TAG_EN
    s_a_tuser = '0;
`endif
    @(posedge clk);
    #1;
    check("rst_v", 64'(m_tvalid), 64'd0);
    check("rst_d", 64'(m_result_tdata), 64'd0);
    check("rst_ra", 64'(s_a_tready), 64'd0);
    check("rst_rb", 64'(s_b_tready), 64'd0);
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    arst = 1'b0;
    tick();

    // Single op: FF*FF with latency 2.
    m_tready = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1, 1'b1);
    check_rdy("single", 1'b1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    check_out("single_lat1", 1'b0, '0);
    tick();
    check_out("single_res", 1'b1, 16'hFE01);
    tick();
    check_out("single_end", 1'b0, '0);

    // Back-to-back, one result per cycle.
    drive(8'h0F, 8'h10, 1'b1, 1'b1);
    tick();
    drive(8'h80, 8'h02, 1'b1, 1'b1);
    tick();
    check_out("b2b_r0", 1'b1, 16'h00F0);
    drive(8'h00, 8'hAB, 1'b1, 1'b1);
    tick();
    check_out("b2b_r1", 1'b1, 16'h0100);
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check_out("b2b_r2", 1'b1, 16'h0000);
    tick();
    check_out("b2b_end", 1'b0, '0);

    // Backpressure: two accepted, third refused until release.
    m_tready = 1'b0;
    drive(8'h0F, 8'h10, 1'b1, 1'b1);
    check_rdy("bp_op0", 1'b1);
    tick();
    drive(8'h80, 8'h02, 1'b1, 1'b1);
    check_rdy("bp_op1", 1'b1);
    tick();
    drive(8'h00, 8'hAB, 1'b1, 1'b1);
    check_rdy("bp_full", 1'b0);
    check_out("bp_hold0", 1'b1, 16'h00F0);
    tick();
    check_rdy("bp_full1", 1'b0);
    check_out("bp_hold1", 1'b1, 16'h00F0);
    tick();
    check_out("bp_hold2", 1'b1, 16'h00F0);
    m_tready = 1'b1;
    check_rdy("bp_rel", 1'b1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    check_out("bp_r1", 1'b1, 16'h0100);
    tick();
    check_out("bp_r2", 1'b1, 16'h0000);
    tick();
    check_out("bp_end", 1'b0, '0);

    // Join: A alone is never accepted.
    drive(8'h05, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_rdy("join_wait", 1'b0);
      tick();
      check_out("join_idle", 1'b0, '0);
    end
    s_b_tdata  = 8'h07;
    s_b_tvalid = 1'b1;
    check_rdy("join_acc", 1'b1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check_out("join_res", 1'b1, 16'h0023);
    tick();
    check_out("join_end", 1'b0, '0);

    // Reset with two products in flight.
    drive(8'hFF, 8'hFF, 1'b1, 1'b1);
    tick();
    drive(8'h0F, 8'h10, 1'b1, 1'b1);
    tick();
    drive(8'h80, 8'h02, 1'b1, 1'b1);
    arst = 1'b1;
    #1;
    check("mrst_v", 64'(m_tvalid), 64'd0);
    check("mrst_d", 64'(m_result_tdata), 64'd0);
    check("mrst_ra", 64'(s_a_tready), 64'd0);
    check("mrst_rb", 64'(s_b_tready), 64'd0);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    arst = 1'b0;
    tick();
    tick();
    check_out("mrst_stale", 1'b0, '0);
    drive(8'h03, 8'h03, 1'b1, 1'b1);
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    check_out("mrst_lat1", 1'b0, '0);
    tick();
    check_out("mrst_res", 1'b1, 16'h0009);
    tick();
    check_out("mrst_end", 1'b0, '0);

    // Random streams with random backpressure against a queue of A*B.
    acc = 0; outs = 0; cyc = 0; acc_last = 1'b0;
    while (outs < N_RND && cyc < 20000) begin
      if (acc_last || !s_a_tvalid) begin
        s_a_tvalid = (acc < N_RND) && ($urandom_range(0, 3) != 0);
        s_a_tdata  = W'($urandom);
`ifdef VEDIC_TAG_EN
        s_a_tuser  = TAG_W'($urandom);
`endif
      end
      if (acc_last || !s_b_tvalid) begin
        s_b_tvalid = (acc < N_RND) && ($urandom_range(0, 3) != 0);
        s_b_tdata  = W'($urandom);
      end
      m_tready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra", 64'(m_result_tdata), 64'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("rnd_prod", 64'(m_result_tdata), 64'(e));
`ifdef VEDIC_TAG_EN
          et = tag_q.pop_front();
          check("rnd_tag", 64'(m_tuser), 64'(et));
`endif
        end
        outs++;
      end
      acc_last = s_a_tready && s_b_tready;
      if (acc_last) begin
        exp_q.push_back((2*W)'(s_a_tdata) * (2*W)'(s_b_tdata));
`ifdef VEDIC_TAG_EN
        tag_q.push_back(s_a_tuser);
`endif
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    check("rnd_done", 64'(outs), 64'(N_RND));
    check("rnd_acc", 64'(acc), 64'(N_RND));
    check("rnd_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
